mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  in  1  single clock; all state updates on its rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 rdy  in  1  1 = run; 0 = pause (all state frozen).
REQ-004 if_req  in  1  instruction-fetch request (always 4-byte read).
REQ-005 if_addr  in  32  fetch byte address.
REQ-006 if_done  out  1  one-cycle pulse; if_inst valid in this cycle.
REQ-007 if_inst  out  32  fetched word, little-endian (byte at addr+0 in [7:0]).
REQ-008 ms_req  in  1  load/store request from MEM stage.
REQ-009 ms_we  in  1  1 = store, 0 = load.
REQ-010 ms_len  in  2  00 = 1 byte, 01 = 2 bytes, 11 = 4 bytes; 10 treated as 4 bytes.
REQ-011 ms_addr  in  32  load/store byte address.
REQ-012 ms_wdata  in  32  store data, byte i from [8i+7:8i].
REQ-013 ms_done  out  1  one-cycle pulse; ms_rdata valid in this cycle for loads.
REQ-014 ms_rdata  out  32  load data, little-endian, zero-extended above ms_len bytes.
REQ-015 ram_din  in  8  memory read data; a byte addressed in cycle c is valid in cycle c+1.
REQ-016 ram_dout  out  8  memory write data.
REQ-017 ram_addr  out  32  memory byte address.
REQ-018 ram_wr  out  1  1 = write ram_dout to ram_addr this cycle.
REQ-019 if_stall_req  out  1  = if_req AND NOT if_done, combinational; feeds stall controller.
REQ-020 ms_stall_req  out  1  = ms_req AND NOT ms_done, combinational.

Function
REQ-021 FSM states IDLE, BUSY, DONE; one transaction in flight at most.
REQ-022 IDLE: at the edge where ms_req=1, grant MEM; else if if_req=1, grant IF; else stay IDLE.
REQ-023 Simultaneous ms_req and if_req in IDLE: MEM wins; IF waits, no loss of the IF request.
REQ-024 At grant: latch addr, we, len (IF: read, 4), wdata; go BUSY with byte counter cnt=0; later request-input changes are ignored until DONE.
REQ-025 No preemption: a granted transaction always runs to completion, even if its request drops.
REQ-026 Read of N bytes: byte i address presented in BUSY cycle i (i=0..N-1); ram_din captured into byte i at the end of BUSY cycle i+1; N+1 BUSY cycles total.
REQ-027 Write of N bytes: ram_wr=1, ram_addr=addr+i, ram_dout=wdata byte i in BUSY cycle i; N BUSY cycles total.
REQ-028 Address arithmetic: addr+i modulo 2^32 (wraps 0xFFFFFFFF -> 0x00000000).
REQ-029 After last BUSY cycle -> DONE for exactly one cycle: owner's done=1, then IDLE.
REQ-030 Request latency from grant edge: 4-byte read done in the 6th cycle (5 cycles after grant), 1-byte read the 3rd, 4-byte write the 5th, 1-byte write the 2nd.
REQ-031 DONE cycle grants nothing; a request still held during DONE is first eligible in the following IDLE cycle.
REQ-032 if_inst / ms_rdata hold their last value outside DONE; unwritten upper bytes of a short load are 0.
REQ-033 ram_wr=0 in IDLE, DONE, all read cycles and whenever rdy=0; ram_addr=0, ram_dout=0 in IDLE.
REQ-034 rdy=0: FSM, counter, latched data and captured bytes frozen; done outputs hold; resumes with the same byte when rdy=1 (memory is paused by the same rdy).

Reset
REQ-035 rst=1 at an edge has priority over rdy and all requests: state IDLE, cnt=0, all outputs and latches 0.
REQ-036 rst mid-transaction aborts it: no done pulse, ram_wr=0 from the next cycle; partial store bytes already written are not undone.

Verification
REQ-037 IF fetch 0x1000 after reset, memory holds 13 00 00 00 -> if_done in cycle 5 after grant, if_inst=0x00000013, ram_addr 0x1000..0x1003, ram_wr always 0.
REQ-038 if_req and ms_req (store, len=01, addr 0x2000, wdata 0xAABBCCDD) in same cycle -> 2 write cycles (0x2000<-DD, 0x2001<-CC), ms_done, one DONE cycle, then IF grant.
REQ-039 Load len=00 at 0x3000 holding 0xF5 -> ms_rdata=0x000000F5, ms_done 2 cycles after grant, ms_stall_req=1 until ms_done.
REQ-040 rdy=0 for 3 cycles in the middle of a 4-byte fetch -> fetch completes 3 cycles later with correct word, no duplicated or skipped byte.
REQ-041 rst pulsed in the 2nd write cycle of a 4-byte store -> ram_wr=0 next cycle, no ms_done, FSM IDLE, new request granted normally.
REQ-042 4-byte read at 0xFFFFFFFE -> addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter -- byte-serial memory arbiter between instruction fetch and MEM.
// Revision: 1.0
// ============================================================================
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_inst,
  input  logic        ms_req,
  input  logic        ms_we,
  input  logic [1:0]  ms_len,
  input  logic [31:0] ms_addr,
  input  logic [31:0] ms_wdata,
  output logic        ms_done,
  output logic [31:0] ms_rdata,
  input  logic [7:0]  ram_din,
  output logic [7:0]  ram_dout,
  output logic [31:0] ram_addr,
  output logic        ram_wr,
  output logic        if_stall_req,
  output logic        ms_stall_req
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  len_q, len_d;
  logic        owner_ms_q, owner_ms_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;
  logic        if_done_q, if_done_d;
  logic        ms_done_q, ms_done_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] ms_rdata_q, ms_rdata_d;

  logic [31:0] byte_addr;
  logic [1:0]  cap_idx;
  logic        last_cycle;

  assign byte_addr  = addr_q + {29'd0, cnt_q};
  // Read data lags the address by one cycle, so cycle cnt stores byte cnt-1.
  assign cap_idx    = cnt_q[1:0] - 2'd1;
  assign last_cycle = we_q ? (cnt_q == len_q - 3'd1) : (cnt_q == len_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    owner_ms_d = owner_ms_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    data_d     = data_q;
    if_done_d  = if_done_q;
    ms_done_d  = ms_done_q;
    if_inst_d  = if_inst_q;
    ms_rdata_d = ms_rdata_q;

    if (state_q == BUSY && !we_q && cnt_q != 3'd0) begin
      data_d[{cap_idx, 3'b000} +: 8] = ram_din;
    end

    case (state_q)
      IDLE: begin
        if (ms_req) begin
          state_d    = BUSY;
          owner_ms_d = 1'b1;
          we_d       = ms_we;
          len_d      = (ms_len == 2'b00) ? 3'd1 : (ms_len == 2'b01) ? 3'd2 : 3'd4;
          addr_d     = ms_addr;
          wdata_d    = ms_wdata;
          cnt_d      = 3'd0;
          data_d     = 32'd0;
        end else if (if_req) begin
          state_d    = BUSY;
          owner_ms_d = 1'b0;
          we_d       = 1'b0;
          len_d      = 3'd4;
          addr_d     = if_addr;
          wdata_d    = 32'd0;
          cnt_d      = 3'd0;
          data_d     = 32'd0;
        end
      end
      BUSY: begin
        if (last_cycle) begin
          state_d = DONE;
          cnt_d   = 3'd0;
          if (owner_ms_q) begin
            ms_done_d = 1'b1;
            if (!we_q) ms_rdata_d = data_d;
          end else begin
            if_done_d = 1'b1;
            if_inst_d = data_d;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE: begin
        state_d   = IDLE;
        if_done_d = 1'b0;
        ms_done_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      len_q      <= 3'd0;
      owner_ms_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      data_q     <= 32'd0;
      if_done_q  <= 1'b0;
      ms_done_q  <= 1'b0;
      if_inst_q  <= 32'd0;
      ms_rdata_q <= 32'd0;
    end else if (rdy) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      owner_ms_q <= owner_ms_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      data_q     <= data_d;
      if_done_q  <= if_done_d;
      ms_done_q  <= ms_done_d;
      if_inst_q  <= if_inst_d;
      ms_rdata_q <= ms_rdata_d;
    end
  end

  assign if_done      = if_done_q;
  assign ms_done      = ms_done_q;
  assign if_inst      = if_inst_q;
  assign ms_rdata     = ms_rdata_q;
  assign ram_wr       = (state_q == BUSY) && we_q && rdy;
  assign ram_addr     = (state_q == BUSY) ? byte_addr : 32'd0;
  assign ram_dout     = ((state_q == BUSY) && we_q) ? wdata_q[{cnt_q[1:0], 3'b000} +: 8] : 8'd0;
  assign if_stall_req = if_req & ~if_done_q;
  assign ms_stall_req = ms_req & ~ms_done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// tb_mem_arbiter -- directed and randomized transactions against a byte memory
// model; expectations come from transaction-level rules (length, latency, bytes).
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        if_req, ms_req, ms_we;
  logic [31:0] if_addr, ms_addr, ms_wdata;
  logic [1:0]  ms_len;
  logic [7:0]  ram_din, ram_dout;
  logic [31:0] ram_addr, if_inst, ms_rdata;
  logic        if_done, ms_done, ram_wr, if_stall_req, ms_stall_req;

  int checks = 0;
  int errors = 0;
  int wr_paused = 0;
  logic [31:0] exp_if = 32'd0;
  logic [31:0] exp_ms = 32'd0;

  logic [7:0]  mem [logic [31:0]];
  logic [31:0] addr_log[$];
  logic [39:0] wr_log[$];

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
    .ms_req(ms_req), .ms_we(ms_we), .ms_len(ms_len), .ms_addr(ms_addr),
    .ms_wdata(ms_wdata), .ms_done(ms_done), .ms_rdata(ms_rdata),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_addr(ram_addr), .ram_wr(ram_wr),
    .if_stall_req(if_stall_req), .ms_stall_req(ms_stall_req)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] fill(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : fill(a);
  endfunction

  // Byte memory with one-cycle read latency, paused by the same rdy.
  always @(posedge clk) begin
    if (rdy) begin
      ram_din <= mem_rd(ram_addr);
      if (ram_wr) begin
        mem[ram_addr] = ram_dout;
        wr_log.push_back({ram_addr, ram_dout});
      end
    end else if (ram_wr) begin
      wr_paused++;
    end
  end

  function automatic int nbytes(input bit is_ms, input logic [1:0] len);
    if (!is_ms) return 4;
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction

  // Issues one request from an idle arbiter and returns observations at the
  // negedge after the done cycle (arbiter idle again).
  task automatic run_txn(input bit is_ms, input bit we, input logic [1:0] len,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int pause_at, input int pause_len,
                         output int lat, output logic [31:0] res, output int bad);
    bit seen;
    addr_log.delete();
    wr_log.delete();
    bad = 0; lat = -1; res = 32'd0; seen = 0;
    if (is_ms) begin
      ms_req = 1'b1; ms_we = we; ms_len = len; ms_addr = addr; ms_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    @(posedge clk);
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(negedge clk);
      if (is_ms ? ms_done : if_done) begin
        seen = 1; lat = k;
        res = is_ms ? ms_rdata : if_inst;
        if (is_ms ? if_done : ms_done) bad++;
        if ((is_ms ? ms_stall_req : if_stall_req) !== 1'b0) bad++;
      end else begin
        if (if_done || ms_done) bad++;
        if ((is_ms ? ms_stall_req : if_stall_req) !== 1'b1) bad++;
        if (rdy) addr_log.push_back(ram_addr);
      end
      if (k == pause_at) rdy = 1'b0;
      if (k == pause_at + pause_len) rdy = 1'b1;
    end
    ms_req = 1'b0; if_req = 1'b0; rdy = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; rdy = 1'b1;
    checks++; if (if_done !== 1'b0) begin errors++; $display("FAIL reset_if_done got %b want 0", if_done); end
    checks++; if (ms_done !== 1'b0) begin errors++; $display("FAIL reset_ms_done got %b want 0", ms_done); end
    checks++; if (if_inst !== 32'd0) begin errors++; $display("FAIL reset_if_inst got %h want 0", if_inst); end
    checks++; if (ms_rdata !== 32'd0) begin errors++; $display("FAIL reset_ms_rdata got %h want 0", ms_rdata); end
    checks++; if (ram_wr !== 1'b0) begin errors++; $display("FAIL reset_ram_wr got %b want 0", ram_wr); end
    checks++; if (ram_addr !== 32'd0) begin errors++; $display("FAIL reset_ram_addr got %h want 0", ram_addr); end
    checks++; if (ram_dout !== 8'd0) begin errors++; $display("FAIL reset_ram_dout got %h want 0", ram_dout); end
    checks++; if ({if_stall_req, ms_stall_req} !== 2'b00) begin errors++; $display("FAIL reset_stall got %b want 00", {if_stall_req, ms_stall_req}); end
  endtask

  task automatic test_fetch;
    int lat, bad; logic [31:0] res;
    mem[32'h1000] = 8'h13; mem[32'h1001] = 8'h00; mem[32'h1002] = 8'h00; mem[32'h1003] = 8'h00;
    run_txn(0, 0, 2'b11, 32'h1000, 32'd0, 0, 0, lat, res, bad);
    checks++; if (lat !== 6) begin errors++; $display("FAIL fetch_latency got %0d want 6", lat); end
    checks++; if (res !== 32'h00000013) begin errors++; $display("FAIL fetch_inst got %h want 00000013", res); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL fetch_handshake got %0d bad cycles want 0", bad); end
    checks++;
    if (addr_log.size() < 4 || addr_log[0] !== 32'h1000 || addr_log[1] !== 32'h1001 ||
        addr_log[2] !== 32'h1002 || addr_log[3] !== 32'h1003) begin
      errors++; $display("FAIL fetch_addrs got %p want 1000..1003", addr_log);
    end
    checks++; if (wr_log.size() !== 0) begin errors++; $display("FAIL fetch_no_write got %0d writes want 0", wr_log.size()); end
    exp_if = 32'h13;
  endtask

  task automatic test_simultaneous;
    int ms_k, if_k, bad; logic [31:0] res;
    wr_log.delete();
    ms_k = -1; if_k = -1; bad = 0; res = 32'd0;
    ms_req = 1'b1; ms_we = 1'b1; ms_len = 2'b01; ms_addr = 32'h2000; ms_wdata = 32'hAABBCCDD;
    if_req = 1'b1; if_addr = 32'h1000;
    @(posedge clk);
    for (int k = 1; k <= 30 && if_k < 0; k++) begin
      @(negedge clk);
      if (ms_done) begin if (ms_k < 0) ms_k = k; ms_req = 1'b0; end
      if (if_done) begin if_k = k; res = if_inst; end
      if (if_k < 0 && if_stall_req !== 1'b1) bad++;
      if (ms_k < 0 && ms_stall_req !== 1'b1) bad++;
    end
    if_req = 1'b0;
    @(negedge clk);
    checks++; if (ms_k !== 3) begin errors++; $display("FAIL simul_ms_done_cycle got %0d want 3", ms_k); end
    checks++; if (if_k !== 10) begin errors++; $display("FAIL simul_if_done_cycle got %0d want 10", if_k); end
    checks++; if (res !== 32'h13) begin errors++; $display("FAIL simul_if_inst got %h want 00000013", res); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL simul_stall got %0d bad cycles want 0", bad); end
    checks++;
    if (wr_log.size() != 2 || wr_log[0] !== {32'h2000, 8'hDD} || wr_log[1] !== {32'h2001, 8'hCC}) begin
      errors++; $display("FAIL simul_writes got %p want 2000<-DD 2001<-CC", wr_log);
    end
    checks++; if (ms_rdata !== exp_ms) begin errors++; $display("FAIL simul_rdata_hold got %h want %h", ms_rdata, exp_ms); end
  endtask

  task automatic test_short_load;
    int lat, bad; logic [31:0] res;
    mem[32'h3000] = 8'hF5; mem[32'h3001] = 8'h77;
    run_txn(1, 0, 2'b00, 32'h3000, 32'd0, 0, 0, lat, res, bad);
    checks++; if (lat !== 3) begin errors++; $display("FAIL short_load_latency got %0d want 3", lat); end
    checks++; if (res !== 32'h000000F5) begin errors++; $display("FAIL short_load_data got %h want 000000F5", res); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL short_load_stall got %0d bad cycles want 0", bad); end
    exp_ms = 32'hF5;
  endtask

  task automatic test_pause;
    int lat, bad; logic [31:0] res, w;
    w = $urandom;
    for (int i = 0; i < 4; i++) mem[32'h4000 + 32'(i)] = w[8*i +: 8];
    run_txn(0, 0, 2'b11, 32'h4000, 32'd0, 3, 3, lat, res, bad);
    checks++; if (lat !== 9) begin errors++; $display("FAIL pause_latency got %0d want 9", lat); end
    checks++; if (res !== w) begin errors++; $display("FAIL pause_data got %h want %h", res, w); end
    checks++;
    if (addr_log.size() != 5 || addr_log[0] !== 32'h4000 || addr_log[1] !== 32'h4001 ||
        addr_log[2] !== 32'h4002 || addr_log[3] !== 32'h4003) begin
      errors++; $display("FAIL pause_addrs got %p want 4000..4003 then one more", addr_log);
    end
    exp_if = w;
  endtask

  task automatic test_wrap;
    int lat, bad; logic [31:0] res, want;
    want = {fill(32'h1), fill(32'h0), fill(32'hFFFFFFFF), fill(32'hFFFFFFFE)};
    run_txn(1, 0, 2'b11, 32'hFFFFFFFE, 32'd0, 0, 0, lat, res, bad);
    checks++;
    if (addr_log.size() < 4 || addr_log[0] !== 32'hFFFFFFFE || addr_log[1] !== 32'hFFFFFFFF ||
        addr_log[2] !== 32'h0 || addr_log[3] !== 32'h1) begin
      errors++; $display("FAIL wrap_addrs got %p want FFFFFFFE FFFFFFFF 0 1", addr_log);
    end
    checks++; if (res !== want) begin errors++; $display("FAIL wrap_data got %h want %h", res, want); end
    exp_ms = want;
  endtask

  task automatic test_reset_mid;
    int lat, bad, seen; logic [31:0] res, want;
    wr_log.delete();
    want = {fill(32'h5003), fill(32'h5002), 8'h33, 8'h44};
    ms_req = 1'b1; ms_we = 1'b1; ms_len = 2'b11; ms_addr = 32'h5000; ms_wdata = 32'h11223344;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; ms_req = 1'b0;
    @(negedge clk);
    checks++; if (ram_wr !== 1'b0) begin errors++; $display("FAIL rstmid_ram_wr got %b want 0", ram_wr); end
    checks++; if (ram_addr !== 32'd0) begin errors++; $display("FAIL rstmid_idle_addr got %h want 0", ram_addr); end
    checks++; if ({if_inst, ms_rdata} !== 64'd0) begin errors++; $display("FAIL rstmid_outputs got %h %h want 0 0", if_inst, ms_rdata); end
    rst = 1'b0;
    exp_if = 32'd0; exp_ms = 32'd0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (ms_done || if_done || ram_wr) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_no_done got %0d active cycles want 0", seen); end
    checks++;
    if (wr_log.size() != 2 || wr_log[0] !== {32'h5000, 8'h44} || wr_log[1] !== {32'h5001, 8'h33}) begin
      errors++; $display("FAIL rstmid_partial_writes got %p want 5000<-44 5001<-33", wr_log);
    end
    run_txn(1, 0, 2'b11, 32'h5000, 32'd0, 0, 0, lat, res, bad);
    checks++; if (lat !== 6 || res !== want) begin errors++; $display("FAIL rstmid_regrant got lat %0d data %h want lat 6 data %h", lat, res, want); end
    exp_ms = want;
  endtask

  task automatic test_random;
    int lat, bad, n, base, pa, pl, exp_lat, ok;
    bit is_ms, we; logic [1:0] len; logic [31:0] a, wd, exp_d, res;
    for (int t = 0; t < 40; t++) begin
      is_ms = ($urandom_range(0, 2) != 0);
      we    = is_ms ? 1'($urandom_range(0, 1)) : 1'b0;
      len   = is_ms ? 2'($urandom_range(0, 3)) : 2'b11;
      case ($urandom_range(0, 3))
        0: a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
        1: a = $urandom;
        default: a = 32'h6000 + 32'($urandom_range(0, 15));
      endcase
      wd = $urandom;
      n = nbytes(is_ms, len);
      exp_d = 32'd0;
      for (int i = 0; i < n; i++) exp_d = exp_d | ({24'd0, mem_rd(a + 32'(i))} << (8 * i));
      base = we ? n + 1 : n + 2;
      pa = $urandom_range(0, base - 1);
      pl = $urandom_range(1, 3);
      exp_lat = base + ((pa != 0) ? pl : 0);
      run_txn(is_ms, we, len, a, wd, pa, pl, lat, res, bad);
      checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", t, lat, exp_lat); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL rand%0d_handshake got %0d bad cycles want 0", t, bad); end
      ok = (addr_log.size() == (we ? n : n + 1));
      for (int i = 0; i < n && i < addr_log.size(); i++) if (addr_log[i] !== a + 32'(i)) ok = 0;
      checks++; if (ok == 0) begin errors++; $display("FAIL rand%0d_addrs got %p base %h len %0d", t, addr_log, a, n); end
      if (we) begin
        ok = (wr_log.size() == n);
        for (int i = 0; i < n && i < wr_log.size(); i++) if (wr_log[i] !== {a + 32'(i), wd[8*i +: 8]}) ok = 0;
        checks++; if (ok == 0) begin errors++; $display("FAIL rand%0d_writes got %p base %h wdata %h", t, wr_log, a, wd); end
        checks++; if (res !== exp_ms) begin errors++; $display("FAIL rand%0d_store_rdata got %h want %h", t, res, exp_ms); end
      end else begin
        checks++; if (res !== exp_d) begin errors++; $display("FAIL rand%0d_read got %h want %h", t, res, exp_d); end
        checks++; if (wr_log.size() !== 0) begin errors++; $display("FAIL rand%0d_read_wr got %0d writes want 0", t, wr_log.size()); end
        if (is_ms) exp_ms = exp_d; else exp_if = exp_d;
      end
      checks++; if ({if_inst, ms_rdata} !== {exp_if, exp_ms}) begin errors++; $display("FAIL rand%0d_hold got %h %h want %h %h", t, if_inst, ms_rdata, exp_if, exp_ms); end
    end
    checks++; if (wr_paused !== 0) begin errors++; $display("FAIL paused_writes got %0d want 0", wr_paused); end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b0;
    if_req = 1'b0; if_addr = 32'd0;
    ms_req = 1'b0; ms_we = 1'b0; ms_len = 2'b00; ms_addr = 32'd0; ms_wdata = 32'd0;
    @(negedge clk);
    test_reset;
    test_fetch;
    test_simultaneous;
    test_short_load;
    test_pause;
    test_wrap;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
